// File: rtl/shift_decode_stage_pkg.sv
// Shared constants and types for the shift decode stage: MIPS shift opcodes/functs
// and the layout of one decoded shift command.
package shift_decode_stage_pkg;

    localparam int INSTR_W = 32;
    localparam int DATA_W  = 32;
    localparam int SAMT_W  = 5;
    localparam int RD_W    = 5;

    localparam logic [5:0] OPCODE_SPECIAL = 6'b000000;
    localparam logic [5:0] FUNCT_SLL      = 6'b000000;
    localparam logic [5:0] FUNCT_SRL      = 6'b000010;
    localparam logic [5:0] FUNCT_SLLV     = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV     = 6'b000110;

    typedef enum logic [2:0] {
        OP_SLL,
        OP_SRL,
        OP_SLLV,
        OP_SRLV,
        OP_ILLEGAL
    } shift_op_e;

    typedef struct packed {
        logic              left;
        logic [SAMT_W-1:0] samt;
        logic [DATA_W-1:0] regis;
        logic [RD_W-1:0]   rd;
        logic              illegal;
    } decoded_t;

    // Everything that is not one of the four logical shifts (sra/srav included) is illegal.
    function automatic shift_op_e classify(input logic [INSTR_W-1:0] instr);
        if (instr[31:26] != OPCODE_SPECIAL) begin
            return OP_ILLEGAL;
        end
        case (instr[5:0])
            FUNCT_SLL:  return OP_SLL;
            FUNCT_SRL:  return OP_SRL;
            FUNCT_SLLV: return OP_SLLV;
            FUNCT_SRLV: return OP_SRLV;
            default:    return OP_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/shift_decode_stage_if.sv
// Handshake and data bundle between upstream, the shift decode stage and the shifter.
interface shift_decode_stage_if
    import shift_decode_stage_pkg::*;
#(
    parameter int CNT_W = 8
);

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [DATA_W-1:0]  in_rs;
    logic [DATA_W-1:0]  in_rt;
    logic               out_valid;
    logic               out_ready;
    logic               left;
    logic [DATA_W-1:0]  regis;
    logic [SAMT_W-1:0]  samt;
    logic [RD_W-1:0]    out_rd;
    logic               out_illegal;
    logic [CNT_W-1:0]   illegal_count;

    // master is the surrounding pipeline (upstream producer plus downstream shifter)
    modport master (
        output in_valid, in_instr, in_rs, in_rt, out_ready,
        input  in_ready, out_valid, left, regis, samt, out_rd, out_illegal, illegal_count
    );

    modport slave (
        input  in_valid, in_instr, in_rs, in_rt, out_ready,
        output in_ready, out_valid, left, regis, samt, out_rd, out_illegal, illegal_count
    );

endinterface

// File: rtl/shift_decode_stage_decode.sv
// Purely combinational decode of one instruction into a shift command.
module shift_decode
    import shift_decode_stage_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    input  logic [DATA_W-1:0]  rs,
    input  logic [DATA_W-1:0]  rt,
    output decoded_t           entry
);

    shift_op_e op;
    logic      unused_fields;

    assign op            = classify(instr);
    assign unused_fields = ^{instr[25:16], rs[DATA_W-1:SAMT_W]};

    // Illegal entries carry only the flag so the shifter sees a harmless zero command.
    always_comb begin
        entry = '0;
        if (op == OP_ILLEGAL) begin
            entry.illegal = 1'b1;
        end else begin
            entry.left  = (op == OP_SLL) || (op == OP_SLLV);
            entry.samt  = ((op == OP_SLLV) || (op == OP_SRLV)) ? rs[SAMT_W-1:0] : instr[10:6];
            entry.regis = rt;
            entry.rd    = instr[15:11];
        end
    end

endmodule

// File: rtl/shift_decode_stage.sv
// Shift decode pipeline stage: decode, two-entry skid buffer (main + skid) and a
// saturating counter of accepted illegal instructions.
module shift_decode_stage
    import shift_decode_stage_pkg::*;
#(
    parameter int CNT_W = 8
)(
    input  logic                  CLOCK_50,
    input  logic                  reset,
    shift_decode_stage_if.slave   bus
);

    decoded_t         dec;
    decoded_t         main_q;
    decoded_t         skid_q;
    logic             main_valid;
    logic             skid_valid;
    logic             accept;
    logic [CNT_W-1:0] count_q;

    shift_decode u_decode (
        .instr (bus.in_instr),
        .rs    (bus.in_rs),
        .rt    (bus.in_rt),
        .entry (dec)
    );

    assign bus.in_ready = !skid_valid;
    assign accept       = bus.in_valid && !skid_valid;

    // Main loads whenever it is empty or draining; skid is preferred so order stays FIFO.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            main_q     <= '0;
            main_valid <= 1'b0;
            skid_q     <= '0;
            skid_valid <= 1'b0;
        end else if (!main_valid || bus.out_ready) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (accept && dec.illegal && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.out_valid     = main_valid;
    assign bus.left          = main_q.left;
    assign bus.samt          = main_q.samt;
    assign bus.regis         = main_q.regis;
    assign bus.out_rd        = main_q.rd;
    assign bus.out_illegal   = main_q.illegal;
    assign bus.illegal_count = count_q;

endmodule

// File: tb/tb_shift_decode_stage.sv
// Self-checking bench for shift_decode_stage against a queue-based reference model.
module tb_shift_decode_stage;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    int   total    = 0;
    int   bad      = 0;
    int   exp_count;

    shift_decode_stage_if #(.CNT_W(8)) bus ();

    shift_decode_stage #(.CNT_W(8)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    initial forever #10 CLOCK_50 = ~CLOCK_50;

    // {out_valid, left, samt, regis, out_rd, out_illegal}
    logic [44:0] obs;
    assign obs = {bus.out_valid, bus.left, bus.samt, bus.regis, bus.out_rd, bus.out_illegal};

    // Reference: {left, samt, regis, rd, illegal} straight from the MIPS shift rules.
    function automatic logic [43:0] ref_decode(logic [31:0] instr, logic [31:0] rs, logic [31:0] rt);
        logic [43:0] illegal_cmd;
        illegal_cmd = {1'b0, 5'd0, 32'd0, 5'd0, 1'b1};
        if (instr[31:26] != 6'd0) return illegal_cmd;
        case (instr[5:0])
            6'd0:    return {1'b1, instr[10:6], rt, instr[15:11], 1'b0};
            6'd2:    return {1'b0, instr[10:6], rt, instr[15:11], 1'b0};
            6'd4:    return {1'b1, 5'(rs % 32), rt, instr[15:11], 1'b0};
            6'd6:    return {1'b0, 5'(rs % 32), rt, instr[15:11], 1'b0};
            default: return illegal_cmd;
        endcase
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [1:0] k;
        k = 2'($urandom % 4);
        return {6'd0, 20'($urandom), 3'b000, k, 1'b0};
    endfunction

    function automatic logic [31:0] rand_illegal();
        logic [5:0] fn;
        if ($urandom % 2 == 1) return {6'($urandom_range(1, 63)), 26'($urandom)};
        fn = 6'($urandom);
        if (fn[5:3] == 3'd0 && fn[0] == 1'b0) fn[5] = 1'b1;
        return {6'd0, 20'($urandom), fn};
    endfunction

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] rs,
                         input logic [31:0] rt, input logic rdy);
        bus.in_valid  = v;
        bus.in_instr  = instr;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        total++; if (obs !== 45'd0) begin bad++; $display("[TB] FAIL reset_outputs: got %h want 0", obs); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.illegal_count !== 8'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", bus.illegal_count); end
        reset = 1'b0;
        tick();
        total++; if (obs !== 45'd0) begin bad++; $display("[TB] FAIL post_reset_outputs: got %h want 0", obs); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_fixed_shift();
        logic [44:0] exp;
        exp = {1'b1, 1'b1, 5'd1, 32'd5, 5'd3, 1'b0};
        drive(1'b1, 32'h00021840, $urandom, 32'd5, 1'b1);
        tick();
        total++; if (obs !== exp) begin bad++; $display("[TB] FAIL fixed_shift: got %h want %h", obs, exp); end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL fixed_shift_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_variable_shift();
        logic [44:0] exp;
        exp = {1'b1, 1'b0, 5'd4, 32'd5, 5'd3, 1'b0};
        drive(1'b1, 32'h00221806, 32'h00000024, 32'd5, 1'b1);
        tick();
        total++; if (obs !== exp) begin bad++; $display("[TB] FAIL variable_shift: got %h want %h", obs, exp); end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] ins [3];
        logic [31:0] rs  [3];
        logic [31:0] rt  [3];
        for (int i = 0; i < 3; i++) begin
            ins[i] = rand_legal();
            rs[i]  = $urandom;
            rt[i]  = $urandom;
        end
        drive(1'b1, ins[0], rs[0], rt[0], 1'b0);
        tick();
        total++; if (obs !== {1'b1, ref_decode(ins[0], rs[0], rt[0])}) begin bad++; $display("[TB] FAIL bp_first: got %h want %h", obs, {1'b1, ref_decode(ins[0], rs[0], rt[0])}); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_after_first: got %b want 1", bus.in_ready); end
        drive(1'b1, ins[1], rs[1], rt[1], 1'b0);
        tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready_after_second: got %b want 0", bus.in_ready); end
        drive(1'b1, ins[2], rs[2], rt[2], 1'b0);
        tick();
        total++; if (obs !== {1'b1, ref_decode(ins[0], rs[0], rt[0])}) begin bad++; $display("[TB] FAIL bp_hold: got %h want %h", obs, {1'b1, ref_decode(ins[0], rs[0], rt[0])}); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready_held: got %b want 0", bus.in_ready); end
        drive(1'b1, ins[2], rs[2], rt[2], 1'b1);
        tick();
        total++; if (obs !== {1'b1, ref_decode(ins[1], rs[1], rt[1])}) begin bad++; $display("[TB] FAIL bp_second_out: got %h want %h", obs, {1'b1, ref_decode(ins[1], rs[1], rt[1])}); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_reopen: got %b want 1", bus.in_ready); end
        tick();
        total++; if (obs !== {1'b1, ref_decode(ins[2], rs[2], rt[2])}) begin bad++; $display("[TB] FAIL bp_third_out: got %h want %h", obs, {1'b1, ref_decode(ins[2], rs[2], rt[2])}); end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_duplicate: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_illegal();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 32'h8C000000, $urandom, 32'h0000_00A5, 1'b1);
        tick();
        total++; if (obs !== {1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 1'b1}) begin bad++; $display("[TB] FAIL illegal_first: got %h want %h", obs, {1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 1'b1}); end
        total++; if (bus.illegal_count !== 8'd1) begin bad++; $display("[TB] FAIL illegal_count_one: got %0d want 1", bus.illegal_count); end
        for (int i = 0; i < 300; i++) begin
            exp_count = (i + 2 > 255) ? 255 : i + 2;
            drive(1'b1, rand_illegal(), $urandom, $urandom, 1'b1);
            tick();
            total++; if (bus.illegal_count !== 8'(exp_count) || bus.out_illegal !== 1'b1) begin
                bad++; $display("[TB] FAIL illegal_count_step %0d: got %0d/%b want %0d/1", i, bus.illegal_count, bus.out_illegal, exp_count);
            end
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        tick();
        total++; if (bus.illegal_count !== 8'd255) begin bad++; $display("[TB] FAIL illegal_saturate: got %0d want 255", bus.illegal_count); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, rand_illegal(), $urandom, $urandom, 1'b0);
        tick();
        drive(1'b1, rand_legal(), $urandom, $urandom, 1'b0);
        tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_full: got in_ready %b want 0", bus.in_ready); end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        total++; if (obs !== 45'd0) begin bad++; $display("[TB] FAIL mid_reset_outputs: got %h want 0", obs); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.illegal_count !== 8'd0) begin bad++; $display("[TB] FAIL mid_reset_count: got %0d want 0", bus.illegal_count); end
        tick();
        reset = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (obs !== 45'd0) begin bad++; $display("[TB] FAIL mid_no_stale %0d: got %h want 0", i, obs); end
        end
    endtask

    task automatic test_stream();
        logic [31:0] ins, rs, rt;
        for (int i = 0; i < 20; i++) begin
            ins = rand_legal();
            rs  = $urandom;
            rt  = $urandom;
            drive(1'b1, ins, rs, rt, 1'b1);
            tick();
            total++; if (obs !== {1'b1, ref_decode(ins, rs, rt)} || bus.in_ready !== 1'b1) begin
                bad++; $display("[TB] FAIL stream %0d: got %h/%b want %h/1", i, obs, bus.in_ready, {1'b1, ref_decode(ins, rs, rt)});
            end
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        tick();
    endtask

    task automatic test_random_handshake();
        logic [43:0] q [$];
        logic        rv, ro, push, pop;
        logic [31:0] ins, rs, rt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_count = 0;
        for (int i = 0; i < 300; i++) begin
            rv  = ($urandom % 4) != 0;
            ro  = ($urandom % 3) != 0;
            ins = ($urandom % 4 == 0) ? rand_illegal() : rand_legal();
            rs  = $urandom;
            rt  = $urandom;
            drive(rv, ins, rs, rt, ro);
            total++; if (bus.in_ready !== (q.size() < 2) || bus.out_valid !== (q.size() > 0)) begin
                bad++; $display("[TB] FAIL rand_flags %0d: got %b%b want %b%b", i, bus.in_ready, bus.out_valid, q.size() < 2, q.size() > 0);
            end
            if (q.size() > 0) begin
                total++; if (obs[43:0] !== q[0]) begin bad++; $display("[TB] FAIL rand_data %0d: got %h want %h", i, obs[43:0], q[0]); end
            end
            push = rv && (q.size() < 2);
            pop  = ro && (q.size() > 0);
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(ref_decode(ins, rs, rt));
                if (ref_decode(ins, rs, rt) & 44'd1 && exp_count < 255) exp_count++;
            end
            tick();
            total++; if (bus.illegal_count !== 8'(exp_count)) begin bad++; $display("[TB] FAIL rand_count %0d: got %0d want %0d", i, bus.illegal_count, exp_count); end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_shift();
        test_variable_shift();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_stream();
        test_random_handshake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_decode_stage.md
SHIFT_DECODE_STAGE -- requirements
Module: shift_decode_stage

Interface
REQ-001 Parameter: CNT_W, 8, width of the illegal-instruction counter.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream presents an instruction.
REQ-006 in_ready  output  1  stage can accept; a transfer occurs when in_valid & in_ready.
REQ-007 in_instr  input  32  MIPS-format instruction word.
REQ-008 in_rs  input  32  rs register value.
REQ-009 in_rt  input  32  rt register value (shift operand).
REQ-010 out_valid  output  1  decoded shift command available.
REQ-011 out_ready  input  1  shifter/writeback accepts; a transfer occurs when out_valid & out_ready.
REQ-012 left  output  1  1 = shift left, 0 = logical shift right; drives the shifter's direction input.
REQ-013 regis  output  32  operand to be shifted.
REQ-014 samt  output  5  shift amount.
REQ-015 out_rd  output  5  destination register tag, instr[15:11].
REQ-016 out_illegal  output  1  instruction is not a supported shift.
REQ-017 illegal_count  output  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-018 Decode: opcode instr[31:26] must be 0; funct instr[5:0] is decoded as follows: 000000 sll, 000010 srl, 000100 sllv, 000110 srlv.
REQ-019 left = 1 for sll/sllv; left = 0 for srl/srlv.
REQ-020 samt = instr[10:6] for sll/srl; samt = in_rs[4:0] for sllv/srlv; in_rs[31:5] is ignored.
REQ-021 regis = in_rt; out_rd = instr[15:11].
REQ-022 Any other opcode/funct (including sra/srav) is illegal: the entry is still forwarded in order with out_illegal = 1 and left = 0, samt = 0, regis = 0, out_rd = 0.
REQ-023 Latency: an accepted instruction appears on the outputs exactly one cycle after acceptance when the output register is free.
REQ-024 Buffering: two-entry skid buffer made of a main (output) register and a skid register; throughput is one instruction per cycle with no bubbles while out_ready = 1.
REQ-025 in_ready = NOT skid_valid; in_ready is a registered signal with no combinational path from out_ready.
REQ-026 Accept while main is empty, or main is draining this cycle: the decoded entry loads main.
REQ-027 Accept while main is held (out_valid & !out_ready): the decoded entry loads skid; in_ready falls the next cycle.
REQ-028 Main drains while skid is valid: skid moves to main and skid clears; a simultaneous accept is impossible because in_ready = 0.
REQ-029 Outputs are stable while out_valid & !out_ready; ordering is strictly FIFO.
REQ-030 illegal_count increments by 1 on each accepted illegal instruction, counted at input acceptance, and saturates at 2^CNT_W-1.

Reset
REQ-031 Asserting reset clears main and skid (out_valid = 0, skid empty) and discards any in-flight entries, including mid-transfer.
REQ-032 During and after reset: in_ready = 1, left = 0, regis = 0, samt = 0, out_rd = 0, out_illegal = 0, illegal_count = 0.

Structure
REQ-033 A shared package holds the opcode/funct constants (FUNCT_SLL, FUNCT_SRL, FUNCT_SLLV, FUNCT_SRLV) and the decoded-entry field widths.
REQ-034 One sub-module, shift_decode (purely combinational instruction to {left, samt, regis, rd, illegal}), is instantiated once; shift_decode_stage contains the buffer and counter.

Verification
REQ-035 Fixed shift: instr 0x00021840 (sll rd=3, rt=2, shamt=1), in_rt = 5 -> next cycle out_valid = 1, left = 1, samt = 1, regis = 5, out_rd = 3, out_illegal = 0.
REQ-036 Variable shift: instr 0x00221806 (srlv), in_rs = 0x00000024, in_rt = 5 -> left = 0, samt = 4, regis = 5.
REQ-037 Backpressure: out_ready = 0 with three back-to-back valid inputs -> first two accepted, in_ready = 0 from the cycle after the second; after out_ready rises, outputs appear in order 1, 2, 3 with no loss or duplication.
REQ-038 Illegal instruction: instr 0x8C000000 -> out_illegal = 1, samt = 0, regis = 0, illegal_count = 1; 300 further illegal instructions -> illegal_count = 255.
REQ-039 Reset mid-operation: both entries full, then reset asserted -> immediately out_valid = 0, in_ready = 1, illegal_count = 0; no stale entry appears after reset release.
REQ-040 Streaming: 20 random legal shifts with out_ready = 1 -> one output per cycle, each matching the reference decode.
